// File: rtl/tl_ul_reg_responder.sv
// TileLink-UL register responder: serves Get/PutFullData/PutPartialData on a bank of 32-bit registers.
// Optional denied-request counter output err_count, enabled by defining TL_UL_REG_RESPONDER_ERR_COUNT_EN.
module tl_ul_reg_responder #(
    parameter int SOURCE_W = 4,
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [1:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_denied,
    output logic [31:0]         d_data
`ifdef TL_UL_REG_RESPONDER_ERR_COUNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    localparam int IDX_W  = ADDR_W - 2;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

    logic [31:0]       regs [NUM_REGS];
    logic              a_fire;
    logic              d_fire;
    logic [IDX_W-1:0]  idx;
    logic [RIDX_W-1:0] ridx;
    logic              is_get;
    logic              is_put;
    logic              misaligned;
    logic              denied;
    logic [3:0]        size_lanes;
    logic [3:0]        wmask;
    logic [31:0]       rdata;

    // Ready-through: a new request may enter whenever the held response leaves this cycle.
    assign a_ready = !d_valid || d_ready;
    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;

    assign idx  = a_address[ADDR_W-1:2];
    assign ridx = idx[RIDX_W-1:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block can infer a latch.
        is_get     = (a_opcode == OP_GET);
        is_put     = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
        misaligned = 1'b0;
        size_lanes = 4'b1111;
        case (a_size)
            2'd0: size_lanes = 4'b0001;
            2'd1: begin
                size_lanes = 4'b0011;
                misaligned = a_address[0];
            end
            2'd2: misaligned = |a_address[1:0];
            default: ;
        endcase
        denied = !(is_get || is_put) || (a_param != 3'd0) || (a_size == 2'd3) ||
                 misaligned || ({1'b0, idx} >= NUM_REGS_W);
        wmask  = a_mask & (size_lanes << a_address[1:0]);
        rdata  = regs[ridx];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_valid  <= 1'b0;
            d_opcode <= '0;
            d_size   <= '0;
            d_source <= '0;
            d_denied <= 1'b0;
            d_data   <= '0;
        end else if (a_fire) begin
            d_valid  <= 1'b1;
            d_opcode <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_size   <= a_size;
            d_source <= a_source;
            d_denied <= denied;
            d_data   <= (is_get && !denied) ? rdata : 32'd0;
        end else if (d_fire) begin
            d_valid <= 1'b0;
        end
    end

    // NOTE: the register bank is architecturally cleared by reset, so it is built from flops rather than a RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (a_fire && is_put && !denied) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) regs[ridx][8*b +: 8] <= a_data[8*b +: 8];
            end
        end
    end

`ifdef TL_UL_REG_RESPONDER_ERR_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (a_fire && denied && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/tl_ul_reg_responder.md
Name: tl_ul_reg_responder

Overview:
- TileLink-UL responder (manager end) serving A-channel requests from one client port and returning D-channel responses.
- Backs a small bank of 32-bit registers; used as the target side of the same A/D channel pair that the TL protocol monitors check.
- One response buffered at a time, with ready-through so back-to-back transactions sustain one per cycle.

Parameters:
- SOURCE_W, 4, width of a_source/d_source.
- ADDR_W, 12, width of a_address.
- NUM_REGS, 16, number of 32-bit registers; legal word index range 0..NUM_REGS-1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  A request valid.
- a_ready  out  1  A request accepted when high with a_valid (a_fire).
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; all others unsupported.
- a_param  in  3  must be 0; nonzero is an error.
- a_size  in  2  log2 bytes (0..2 legal; 3 is an error).
- a_source  in  SOURCE_W  transaction ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid  out  1  response valid.
- d_ready  in  1  response accepted when high with d_valid (d_fire).
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_size  out  2  echo of a_size.
- d_source  out  SOURCE_W  echo of a_source.
- d_denied  out  1  request rejected.
- d_data  out  32  read data; 0 for writes and denied requests.

Behaviour:
- Reset: d_valid=0; d_opcode, d_size, d_source, d_denied, d_data=0; all registers=0. Reset mid-response drops the pending response without it ever firing.
- a_ready = !d_valid | d_ready (combinational). No combinational path from any a_* input to any d_* output.
- On a_fire, the response register loads on the same edge and d_valid=1 the next cycle. Latency is 1 cycle.
- d_valid and all d_* fields hold stable until d_fire.
- d_fire with no a_fire: d_valid->0.
- d_fire and a_fire in the same cycle: the new response replaces the old one and d_valid stays 1.
- Index = a_address[ADDR_W-1:2].
- Error conditions, any of which makes the request denied:
  - unsupported opcode;
  - a_param!=0;
  - a_size==3;
  - address misaligned to size (a_address mod 2^a_size != 0);
  - index >= NUM_REGS.
- Denied request: no register update; d_denied=1; d_data=0; d_opcode=1 for Get, otherwise 0 (unsupported opcodes return 0).
- Accepted Get: d_opcode=1; d_data = register value sampled at the a_fire edge.
- Accepted Put: d_opcode=0, d_data=0.
  - Register bytes are updated where a_mask bit=1, on the a_fire edge.
  - PutFullData and PutPartialData both honour a_mask.
  - Mask lanes outside the addressed size are ignored.
- A Get accepted in the cycle after a Put to the same index returns the new value.
- No bus-visible hazards: at most one request is accepted per cycle.

Optional Feature:
- Macro TL_UL_REG_RESPONDER_ERR_COUNT_EN.
- Defined:
  - Adds output err_count (8 bits).
  - Increments on every a_fire that produces d_denied=1 and saturates at 255.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Put then Get: PutFullData addr 0x008, mask 0xF, data 0xDEADBEEF, src 3 -> d_opcode 0, d_denied 0, src 3. Get addr 0x008 -> d_opcode 1, d_data 0xDEADBEEF.
- Partial write: PutPartialData addr 0x008, mask 0x2, data 0x00005500 over 0xDEADBEEF -> following Get returns 0xDEAD55EF.
- Errors:
  - Get addr 0x040 (index 16) -> d_denied 1, d_data 0, registers unchanged.
  - Opcode 2 -> d_denied 1, d_opcode 0.
  - Size 2 at addr 0x002 -> denied.
  - With macro defined: err_count=3 after these three requests.
- Backpressure: hold d_ready=0 for 5 cycles after a Get -> a_ready=0 and d_* stable throughout. Raise d_ready with a new a_valid -> a_fire and d_fire occur in the same cycle, and the next response appears on the following cycle.
- Throughput: d_ready=1 and 8 back-to-back Gets -> 8 consecutive d_valid cycles with sources in order.
- Reset mid-response: assert reset while d_valid=1 and d_ready=0 -> d_valid=0 immediately, all registers read 0 after reset release.
